// File: rtl/ir_disp_scheduler.sv
// Time-shares a 4-digit multiplexed seven-segment display between the IR address
// and IR command, with digit scanning, inter-digit blanking and leading-zero suppression.
module ir_disp_scheduler #(
    parameter int unsigned SCAN_DIV    = 256,
    parameter int unsigned BLANK       = 8,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        rep,
    input  logic [15:0] cmd_bcd,
    input  logic [15:0] addr_hex,
    output logic [3:0]  digit,
    output logic        blank,
    output logic [3:0]  sel,
    output logic        src,
    output logic        frame_tick
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] SlotLast  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SlotBlank = SW'(BLANK);
    localparam logic [HW-1:0] HoldInit  = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {StIdle, StShowAddr, StShowCmd} state_e;

    state_e      state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]  idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        pend_load_q, pend_load_d;
    logic        pend_rep_q, pend_rep_d;
    logic [15:0] snap_q, snap_d;

    logic boundary;
    logic suppress;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            idx_q       <= 2'd0;
            hold_q      <= '0;
            pend_load_q <= 1'b0;
            pend_rep_q  <= 1'b0;
            snap_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            pend_load_q <= pend_load_d;
            pend_rep_q  <= pend_rep_d;
            snap_q      <= snap_d;
        end
    end

    always_comb begin
        boundary    = (slot_q == SlotLast) && (idx_q == 2'd3);
        slot_d      = (slot_q == SlotLast) ? '0 : slot_q + SW'(1);
        idx_d       = (slot_q == SlotLast) ? idx_q + 2'd1 : idx_q;
        state_d     = state_q;
        hold_d      = hold_q;
        pend_load_d = pend_load_q | load;
        pend_rep_d  = pend_rep_q | rep;
        snap_d      = snap_q;

        // Every branch at a boundary consumes both pending flags, including pulses
        // arriving on the boundary cycle itself.
        if (boundary) begin
            pend_load_d = 1'b0;
            pend_rep_d  = 1'b0;
            if (pend_load_q || load) begin
                state_d = StShowAddr;
                hold_d  = HoldInit;
            end else if (state_q == StShowAddr) begin
                if (pend_rep_q || rep) begin
                    hold_d = HoldInit;
                end else begin
                    if (hold_q == HW'(1)) begin
                        state_d = StShowCmd;
                    end
                    hold_d = hold_q - HW'(1);
                end
            end
            case (state_d)
                StShowAddr: snap_d = addr_hex;
                StShowCmd:  snap_d = cmd_bcd;
                default:    snap_d = snap_q;
            endcase
        end
    end

    always_comb begin
        unique case (idx_q)
            2'd0: suppress = 1'b0;
            2'd1: suppress = (snap_q[15:4] == 12'h000);
            2'd2: suppress = (snap_q[15:8] == 8'h00);
            2'd3: suppress = (snap_q[15:12] == 4'h0);
        endcase

        digit      = snap_q[{idx_q, 2'b00} +: 4];
        src        = (state_q == StShowAddr);
        frame_tick = boundary;
        sel        = 4'b1111;
        blank      = 1'b1;
        if (state_q != StIdle) begin
            if (slot_q >= SlotBlank) begin
                sel = ~(4'b0001 << idx_q);
            end
            blank = (slot_q < SlotBlank) || ((state_q == StShowCmd) && suppress);
        end
    end

endmodule

// File: tb/tb_ir_disp_scheduler.sv
// Self-checking bench for ir_disp_scheduler: directed scenarios plus random pulses,
// compared against a cycle-count based behavioural model of the display schedule.
module tb_ir_disp_scheduler;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int HF = 3;
    localparam int FR = 4 * SD;
    localparam logic [10:0] RstVec = {4'hF, 1'b1, 4'h0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        rep = 1'b0;
    logic [15:0] cmd_bcd = 16'h0000;
    logic [15:0] addr_hex = 16'h0000;
    logic [3:0]  digit;
    logic        blank;
    logic [3:0]  sel;
    logic        src;
    logic        frame_tick;

    int total = 0;
    int bad = 0;

    // Model: cycles since reset release, display mode (0 idle, 1 address, 2 command),
    // address frames left, pending pulses and the displayed 16-bit value.
    int          t;
    int          m_mode;
    int          m_hold;
    bit          m_pl, m_pr;
    logic [15:0] m_snap;

    ir_disp_scheduler #(
        .SCAN_DIV   (SD),
        .BLANK      (BL),
        .HOLD_FRAMES(HF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .rep       (rep),
        .cmd_bcd   (cmd_bcd),
        .addr_hex  (addr_hex),
        .digit     (digit),
        .blank     (blank),
        .sel       (sel),
        .src       (src),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] obs();
        return {sel, blank, digit, src, frame_tick};
    endfunction

    function automatic logic [10:0] exp_vec();
        int slot, idx;
        logic [3:0]  s;
        logic        b;
        logic [15:0] upper;
        slot  = t % SD;
        idx   = (t / SD) % 4;
        upper = m_snap >> (4 * idx);
        s = (m_mode != 0 && slot >= BL) ? ~(4'b0001 << idx) : 4'hF;
        b = (m_mode == 0) || (slot < BL) || (m_mode == 2 && idx > 0 && upper == 16'h0);
        return {s, b, upper[3:0], m_mode == 1, (slot == SD - 1 && idx == 3)};
    endfunction

    task automatic model_reset();
        t = 0; m_mode = 0; m_hold = 0; m_pl = 0; m_pr = 0; m_snap = 16'h0;
    endtask

    task automatic model_step(input bit l, input bit r);
        bit pl, pr;
        if (t % FR == FR - 1) begin
            pl = m_pl | l;
            pr = m_pr | r;
            m_pl = 0;
            m_pr = 0;
            if (pl) begin
                m_mode = 1;
                m_hold = HF;
            end else if (m_mode == 1) begin
                if (pr) m_hold = HF;
                else begin
                    m_hold--;
                    if (m_hold == 0) m_mode = 2;
                end
            end
            if (m_mode == 1) m_snap = addr_hex;
            else if (m_mode == 2) m_snap = cmd_bcd;
        end else begin
            m_pl |= l;
            m_pr |= r;
        end
        t++;
    endtask

    task automatic cyc(input bit l, input bit r);
        load = l;
        rep  = r;
        @(posedge clk);
        model_step(l, r);
        #1;
        load = 1'b0;
        rep  = 1'b0;
    endtask

    task automatic test_reset();
        int ticks = 0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs() !== RstVec) begin
            $display("FAIL reset_values got=%h want=%h", obs(), RstVec); bad++;
        end
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0);
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL idle_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            total++;
            if (sel !== 4'hF || blank !== 1'b1) begin
                $display("FAIL idle_dark t=%0d got=%b/%b want=1111/1", t, sel, blank); bad++;
            end
            ticks += int'(frame_tick);
        end
        total++;
        if (ticks !== 3) begin
            $display("FAIL idle_ticks got=%0d want=3", ticks); bad++;
        end
    endtask

    task automatic test_addr_cmd();
        int src_cyc = 0;
        int lit = 0;
        addr_hex = 16'h00A5;
        cmd_bcd  = 16'h0042;
        repeat (5) cyc(0, 0);
        cyc(1, 0);
        for (int i = 0; i < 7 * FR; i++) begin
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL addr_cmd_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            src_cyc += int'(src);
            cyc(0, 0);
        end
        total++;
        if (src_cyc !== 3 * FR) begin
            $display("FAIL addr_dwell got=%0d want=%0d", src_cyc, 3 * FR); bad++;
        end
        for (int i = 0; i < FR; i++) begin
            if (!blank) begin
                lit++;
                total++;
                if (!((sel == 4'b1110 && digit == 4'd2) || (sel == 4'b1101 && digit == 4'd4))) begin
                    $display("FAIL cmd_digits sel=%b got=%h want=2@1110/4@1101", sel, digit); bad++;
                end
            end
            cyc(0, 0);
        end
        total++;
        if (lit !== 12) begin
            $display("FAIL cmd_lit_cycles got=%0d want=12", lit); bad++;
        end
    endtask

    task automatic test_rep();
        int cnt = 0;
        int seen = -1;
        bit r;
        addr_hex = 16'h1234;
        cyc(1, 0);
        for (int i = 0; i < 10 * FR; i++) begin
            r = (seen >= 0 && i == seen + FR + 8);
            cyc(0, r);
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL rep_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            if (src) begin
                cnt++;
                if (seen < 0) seen = i;
            end
        end
        total++;
        if (cnt !== 5 * FR) begin
            $display("FAIL rep_dwell got=%0d want=%0d", cnt, 5 * FR); bad++;
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        addr_hex = 16'hBEEF;
        while (t % FR != FR - 1) cyc(0, 0);
        cyc(1, 1);
        total++;
        if (src !== 1'b1 || digit !== 4'hF) begin
            $display("FAIL boundary_load got=%b/%h want=1/f", src, digit); bad++;
        end
        cnt = 1;
        for (int i = 0; i < 6 * FR; i++) begin
            cyc(0, 0);
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL boundary_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            cnt += int'(src);
        end
        total++;
        if (cnt !== 3 * FR) begin
            $display("FAIL boundary_dwell got=%0d want=%0d", cnt, 3 * FR); bad++;
        end
        while (t % FR != 12) cyc(0, 0);
        cyc(1, 1);
        cnt = 0;
        for (int i = 0; i < 7 * FR; i++) begin
            cyc(0, 0);
            cnt += int'(src);
        end
        total++;
        if (cnt !== 3 * FR) begin
            $display("FAIL load_rep_dwell got=%0d want=%0d", cnt, 3 * FR); bad++;
        end
    endtask

    task automatic test_zero_cmd();
        int lit = 0;
        int seven = 0;
        cmd_bcd = 16'h0000;
        cyc(0, 0);
        while (t % FR != 0) cyc(0, 0);
        for (int i = 0; i < FR; i++) begin
            if (!blank) begin
                lit++;
                total++;
                if (sel !== 4'b1110 || digit !== 4'h0) begin
                    $display("FAIL zero_digit got=%b/%h want=1110/0", sel, digit); bad++;
                end
            end
            cyc(0, 0);
        end
        total++;
        if (lit !== 6) begin
            $display("FAIL zero_lit got=%0d want=6", lit); bad++;
        end
        repeat (10) cyc(0, 0);
        cmd_bcd = 16'h0007;
        for (int i = 10; i < FR; i++) begin
            if (!blank && digit == 4'h7) seven++;
            cyc(0, 0);
        end
        total++;
        if (seven !== 0) begin
            $display("FAIL early_update got=%0d want=0", seven); bad++;
        end
        for (int i = 0; i < FR; i++) begin
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL seven_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            if (!blank && digit == 4'h7 && sel == 4'b1110) seven++;
            cyc(0, 0);
        end
        total++;
        if (seven !== 6) begin
            $display("FAIL seven_lit got=%0d want=6", seven); bad++;
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        addr_hex = 16'h5A5A;
        cyc(1, 0);
        while (!src && t < 100000) begin
            if (cnt > 2 * FR) break;
            cnt++;
            cyc(0, 0);
        end
        repeat (20) cyc(0, 0);
        reset = 1'b0;
        #1;
        total++;
        if (obs() !== RstVec) begin
            $display("FAIL mid_reset got=%h want=%h", obs(), RstVec); bad++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (obs() !== RstVec) begin
            $display("FAIL mid_reset_held got=%h want=%h", obs(), RstVec); bad++;
        end
        reset = 1'b1;
        model_reset();
        cyc(1, 0);
        cnt = 0;
        for (int i = 0; i < 6 * FR; i++) begin
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL post_reset_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
            cnt += int'(src);
            cyc(0, 0);
        end
        total++;
        if (cnt !== 3 * FR) begin
            $display("FAIL post_reset_dwell got=%0d want=%0d", cnt, 3 * FR); bad++;
        end
    endtask

    task automatic test_random();
        bit l, r;
        logic [15:0] c;
        for (int i = 0; i < 1500; i++) begin
            l = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 5) addr_hex = 16'($urandom);
            if ($urandom_range(0, 99) < 5) begin
                for (int k = 0; k < 4; k++) c[4*k +: 4] = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 1) c[15:8] = 8'h00;
                cmd_bcd = c;
            end
            cyc(l, r);
            total++;
            if (obs() !== exp_vec()) begin
                $display("FAIL random_model t=%0d got=%h want=%h", t, obs(), exp_vec()); bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_addr_cmd();
        test_rep();
        test_back_to_back();
        test_zero_cmd();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_disp_scheduler.md
# ir_disp_scheduler

Time-shares the 4-digit multiplexed seven-segment display between two sources: the decoded IR address (4 hex nibbles) and the decoded IR command (4 BCD digits). It generates digit scanning with inter-digit blanking and leading-zero suppression. On each new IR frame it shows the address for a fixed number of refresh frames, then reverts to the command. It sits between the IR decoder / BIN-to-BCD stage and the nibble-to-segment encoder plus anode drivers.

## Interface
- SCAN_DIV, 256: clock cycles per digit slot (>= BLANK+1, power of two not required)
- BLANK, 8: dead cycles at the start of each slot (anti-ghosting)
- HOLD_FRAMES, 64: refresh frames the address is shown after a load (>= 1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- load  in  1  one-cycle pulse, new IR frame decoded
- rep  in  1  one-cycle pulse, IR repeat code received
- cmd_bcd  in  16  command as 4 BCD digits, [3:0] = units
- addr_hex  in  16  address as 4 hex nibbles, [3:0] = least significant
- digit  out  4  nibble for the segment encoder
- blank  out  1  1 = encoder must drive all segments off
- sel  out  4  active-low one-hot digit enable, bit0 = rightmost digit
- src  out  1  0 = command on display, 1 = address
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- slot counter counts 0..SCAN_DIV-1 and wraps. Digit index idx (0..3) increments when slot = SCAN_DIV-1. A frame is 4 slots.
- Frame boundary: the cycle where slot = SCAN_DIV-1 and idx = 3. frame_tick = 1 on that cycle only.
- States: IDLE, SHOW_ADDR, SHOW_CMD. Mode changes and source snapshots happen only at frame boundaries, so there is no tearing.
- load sets pend_load, and rep sets pend_rep. If a pulse arrives on the boundary cycle itself, it is consumed at that boundary.
- At a boundary, in priority order:
  - pend_load: go to SHOW_ADDR, hold_cnt = HOLD_FRAMES, clear both pend flags.
  - Else in SHOW_ADDR with pend_rep: hold_cnt = HOLD_FRAMES, clear pend_rep.
  - Else in SHOW_ADDR: if hold_cnt = 1, go to SHOW_CMD; otherwise decrement hold_cnt.
  - In IDLE or SHOW_CMD, pend_rep is cleared with no other effect.
- Snapshot register: at every boundary, latches addr_hex if the next state is SHOW_ADDR, or cmd_bcd if it is SHOW_CMD. It holds its value in IDLE.
- IDLE: sel = 4'b1111 and blank = 1 permanently. Counters still run.
- Active states:
  - sel = ~(1 << idx) when slot >= BLANK, else 4'b1111.
  - digit = snapshot nibble idx.
  - blank = 1 when slot < BLANK or the digit is suppressed.
- Leading-zero suppression applies to SHOW_CMD only. Digit k (k >= 1) is suppressed when nibbles k..3 are all zero. Digit 0 is never suppressed. The address always shows all 4 nibbles.
- src = 1 in SHOW_ADDR, else 0.

## Timing
- Reset values: slot 0, idx 0, state IDLE, hold_cnt 0, pend flags 0, snapshot 0, sel 4'b1111, blank 1, digit 0, src 0, frame_tick 0.
- All outputs are decoded from registered state only; there is no input-to-output combinational path.
- New state and snapshot are visible on the cycle after the boundary (slot 0, idx 0).
- Load-to-display latency is between 1 and 4*SCAN_DIV cycles.
- Address dwell is exactly HOLD_FRAMES frames per load or rep, counted from the boundary that applied it.
- load and rep in the same cycle: load wins.
- Multiple loads inside one frame collapse to one.
- Input changes mid-frame are not shown until the next boundary.
- Reset asserted mid-operation returns to IDLE immediately, with the display dark. Operation resumes on the first clk edge after deassertion.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK=2, HOLD_FRAMES=3 (frame = 32 cycles).
- Reset, then 100 cycles with no load -> sel = 1111 and blank = 1 throughout; frame_tick every 32 cycles.
- Apply addr_hex=16'h00A5, cmd_bcd=16'h0042, and pulse load at cycle 5:
  - Next boundary: src = 1 for 3 frames, showing 5, A, 0, 0.
  - Then src = 0 showing 2, 4 with digits 2-3 blanked.
  - sel low only for slots 2..7 of each slot.
- In SHOW_ADDR, pulse rep in frame 2 -> address shown for 3 frames after that boundary (5 in total), then command.
- load on the exact boundary cycle -> SHOW_ADDR from the following cycle. load+rep in the same cycle -> behaves as load only.
- cmd_bcd=16'h0000 in SHOW_CMD -> only digit 0 is lit, showing 0. Changing cmd_bcd mid-frame to 16'h0007 -> 7 appears only after the next frame_tick.
- Assert reset in the middle of SHOW_ADDR -> all outputs return to reset values asynchronously; a new load after release restarts with the full 3-frame address dwell.
